// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU/DMA request ports and memory bus of the arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;
  logic          c_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;

  // Arbiter view: serves the two requesters and masters the memory bus.
  modport master (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_ack, c_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  // Environment view: requesters plus the memory responder.
  modport slave (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_ack, c_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/DMA memory arbiter with access timeout
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO = 15
) (
  input  logic          clock,
  input  logic          resetn,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       G_CPU = 1'b0;
  localparam logic       G_DMA = 1'b1;
  localparam logic [7:0] TO_M1 = 8'(TO - 1);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_cnt;
  logic          r_grant;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_any_req;
  logic          w_grant;
  logic          w_timeout;

  // Winner selection: a lone requester wins; on a tie the one not granted last.
  always_comb begin
    w_any_req = bus.c_req | bus.d_req;
    w_grant   = G_CPU;
    if (bus.c_req && bus.d_req) begin
      w_grant = ~r_grant;
    end else if (bus.d_req) begin
      w_grant = G_DMA;
    end
  end

  // The last BUSY cycle without m_ready is the TO-th one (counter counts from 0).
  assign w_timeout = !bus.m_ready && (r_cnt == TO_M1);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; requests only matter in IDLE, m_ready only in BUSY.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = BUSY;
      BUSY:    if (bus.m_ready || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the winner's access; r_grant doubles as winner and last-granted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_grant <= G_DMA;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_any_req) begin
      r_grant <= w_grant;
      r_we    <= (w_grant == G_DMA) ? bus.d_we    : bus.c_we;
      r_addr  <= (w_grant == G_DMA) ? bus.d_addr  : bus.c_addr;
      r_wdata <= (w_grant == G_DMA) ? bus.d_wdata : bus.c_wdata;
    end
  end

  // Wait-cycle counter, cleared whenever the arbiter is not in BUSY.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state != BUSY) begin
      r_cnt <= '0;
    end else if (!bus.m_ready) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Latch completion status and read data at the end of BUSY.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_err     <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else if (r_state == BUSY) begin
      if (bus.m_ready) begin
        r_err <= 1'b0;
        if (!r_we) begin
          if (r_grant == G_DMA) begin
            r_d_rdata <= bus.m_rdata;
          end else begin
            r_c_rdata <= bus.m_rdata;
          end
        end
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.m_en    = (r_state == BUSY);
  assign bus.m_we    = (r_state == BUSY) & r_we;
  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;

  assign bus.c_ack   = (r_state == DONE) & (r_grant == G_CPU);
  assign bus.c_err   = (r_state == DONE) & (r_grant == G_CPU) & r_err;
  assign bus.d_ack   = (r_state == DONE) & (r_grant == G_DMA);
  assign bus.d_err   = (r_state == DONE) & (r_grant == G_DMA) & r_err;
  assign bus.c_rdata = r_c_rdata;
  assign bus.d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int NC = 1024;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TO(TO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // memory plan: one entry per access in grant order (wait cycles, read data)
  int          mw[$];
  logic [31:0] mrd[$];
  int          mi = 0;
  int          ri = 0;

  // expected per-cycle outputs, filled by the transaction model
  bit          e_men [NC];
  bit          e_we  [NC];
  logic [31:0] e_addr[NC];
  logic [31:0] e_wd  [NC];
  bit          e_cack[NC];
  bit          e_cerr[NC];
  bit          e_dack[NC];
  bit          e_derr[NC];
  bit          e_cupd[NC];
  bit          e_dupd[NC];
  logic [31:0] e_crd [NC];
  logic [31:0] e_drd [NC];
  logic [31:0] x_crd   = 32'h0;
  logic [31:0] x_drd   = 32'h0;
  bit          m_last  = 1'b1;
  int          free_at = 0;

  // monitor records
  logic [31:0] rise_addr[$];
  int          rise_cyc[$];
  int          en_len[$];
  int          cur_len = 0;
  int          c_acks  = 0;
  int          d_acks  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic plan(input int w, input logic [31:0] rd);
    mw.push_back(w);
    mrd.push_back(rd);
  endtask

  // Whole-access timeline: L busy cycles (w+1, capped at TO), then one ack cycle.
  task automatic schedule(input int t);
    bit g, tmo, we;
    int w, len;
    logic [31:0] rd, ad, wd;
    if (bus.c_req && bus.d_req) g = ~m_last;
    else g = bus.d_req;
    m_last = g;
    w  = (mi < mw.size()) ? mw[mi] : 0;
    rd = (mi < mrd.size()) ? mrd[mi] : 32'h0;
    mi++;
    tmo = (w + 1 > TO);
    len = tmo ? TO : w + 1;
    we  = g ? bus.d_we : bus.c_we;
    ad  = g ? bus.d_addr : bus.c_addr;
    wd  = g ? bus.d_wdata : bus.c_wdata;
    for (int j = 0; j < len; j++) begin
      e_men[t+j]  = 1'b1;
      e_we[t+j]   = we;
      e_addr[t+j] = ad;
      e_wd[t+j]   = wd;
    end
    if (g) begin
      e_dack[t+len] = 1'b1;
      e_derr[t+len] = tmo;
      if (!tmo && !we) begin e_dupd[t+len] = 1'b1; e_drd[t+len] = rd; end
    end else begin
      e_cack[t+len] = 1'b1;
      e_cerr[t+len] = tmo;
      if (!tmo && !we) begin e_cupd[t+len] = 1'b1; e_crd[t+len] = rd; end
    end
    free_at = t + len + 1;
  endtask

  // Model: at each edge, an idle arbiter with a pending request starts an access.
  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
    if (resetn && (cyc - 1 >= free_at) && (bus.c_req || bus.d_req) && cyc + 20 < NC)
      schedule(cyc);
  end

  // Model: reset wipes every outstanding expectation.
  initial forever begin
    @(negedge resetn);
    for (int i = cyc; i < NC; i++) begin
      e_men[i] = 0; e_we[i] = 0; e_cack[i] = 0; e_cerr[i] = 0;
      e_dack[i] = 0; e_derr[i] = 0; e_cupd[i] = 0; e_dupd[i] = 0;
    end
    x_crd   = 32'h0;
    x_drd   = 32'h0;
    m_last  = 1'b1;
    free_at = 0;
  end

  // Compare every cycle against the model.
  initial forever begin
    @(negedge clock);
    if (cyc < NC) begin
      if (e_cupd[cyc]) x_crd = e_crd[cyc];
      if (e_dupd[cyc]) x_drd = e_drd[cyc];
      chk("m_en", bus.m_en, e_men[cyc]);
      if (e_men[cyc]) begin
        chk("m_we", bus.m_we, e_we[cyc]);
        chk("m_addr", bus.m_addr, e_addr[cyc]);
        chk("m_wdata", bus.m_wdata, e_wd[cyc]);
      end else begin
        chk("m_we_off", bus.m_we, 1'b0);
      end
      chk("c_ack", bus.c_ack, e_cack[cyc]);
      chk("c_err", bus.c_err, e_cerr[cyc]);
      chk("d_ack", bus.d_ack, e_dack[cyc]);
      chk("d_err", bus.d_err, e_derr[cyc]);
      chk("c_rdata", bus.c_rdata, x_crd);
      chk("d_rdata", bus.d_rdata, x_drd);
      if (!resetn) begin
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
      end
    end
  end

  // Memory responder: m_ready on the (w+1)-th busy cycle of each access.
  initial begin
    int k, w;
    k = 0;
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (bus.m_en) begin
        k++;
        w = (ri < mw.size()) ? mw[ri] : 0;
        bus.m_ready = (k == w + 1);
        bus.m_rdata = (k == w + 1) ? mrd[ri] : (32'hBAD0_0000 + k);
      end else begin
        if (k > 0) begin ri++; k = 0; end
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'hFFFF_0000 ^ cyc;
      end
    end
  end

  // Monitor: access start addresses, strobe lengths and ack counts.
  initial forever begin
    @(negedge clock);
    if (bus.m_en) begin
      if (cur_len == 0) begin
        rise_addr.push_back(bus.m_addr);
        rise_cyc.push_back(cyc);
      end
      cur_len++;
    end else if (cur_len > 0) begin
      en_len.push_back(cur_len);
      cur_len = 0;
    end
    if (bus.c_ack) c_acks++;
    if (bus.d_ack) d_acks++;
  end

  task automatic wait_ack(input bit dma, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clock);
      if (dma ? bus.d_ack : bus.c_ack) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_wait: no ack from requester %0d within 60 cycles", dma);
    end
  endtask

  task automatic wait_any(output bit dma, output bit ok);
    ok  = 1'b0;
    dma = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clock);
      if (bus.c_ack || bus.d_ack) begin ok = 1'b1; dma = bus.d_ack; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_wait_any: no ack within 60 cycles");
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit ok, who;
    int base, rc, a1, ca;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("lit_rst_m_en", bus.m_en, 1'b0);
    chk("lit_rst_c_ack", bus.c_ack, 1'b0);
    chk("lit_rst_d_err", bus.d_err, 1'b0);
    chk("lit_rst_c_rdata", bus.c_rdata, 32'h0);
    chk("lit_rst_m_addr", bus.m_addr, 32'h0);

    // tie right after reset, both requests held: CPU, DMA, CPU
    plan(0, 32'h1111_0001); plan(0, 32'h2222_0002); plan(0, 32'h1111_0003);
    bus.c_addr = 32'h10; bus.d_addr = 32'h20;
    bus.c_req = 1; bus.d_req = 1;
    resetn = 1;
    base = rise_addr.size();
    for (int n = 0; n < 3; n++) wait_any(who, ok);
    next_cycle();
    bus.c_req = 0; bus.d_req = 0;
    repeat (3) next_cycle();
    chk("lit_tie_count", rise_addr.size(), base + 3);
    if (rise_addr.size() >= base + 3) begin
      chk("lit_tie_addr0", rise_addr[base], 32'h10);
      chk("lit_tie_addr1", rise_addr[base+1], 32'h20);
      chk("lit_tie_addr2", rise_addr[base+2], 32'h10);
      chk("lit_tie_spacing", rise_cyc[base+1] - rise_cyc[base], 3);
    end
    chk("lit_tie_c_acks", c_acks, 2);
    chk("lit_tie_d_acks", d_acks, 1);
    chk("lit_tie_c_rdata", bus.c_rdata, 32'h1111_0003);
    chk("lit_tie_d_rdata", bus.d_rdata, 32'h2222_0002);

    // CPU read with immediate m_ready
    plan(0, 32'hDEADBEEF);
    bus.c_we = 0; bus.c_addr = 32'h100; bus.c_req = 1;
    rc = cyc;
    wait_ack(1'b0, ok);
    chk("lit_rd_latency", cyc - rc, 2);
    chk("lit_rd_c_rdata", bus.c_rdata, 32'hDEADBEEF);
    chk("lit_rd_c_err", bus.c_err, 1'b0);
    chk("lit_rd_d_ack", bus.d_ack, 1'b0);
    next_cycle();
    bus.c_req = 0;
    repeat (2) next_cycle();

    // DMA write with three wait cycles
    plan(3, 32'h5555_AAAA);
    bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678; bus.d_req = 1;
    base = en_len.size();
    wait_ack(1'b1, ok);
    chk("lit_wr_d_err", bus.d_err, 1'b0);
    chk("lit_wr_d_rdata", bus.d_rdata, 32'h2222_0002);
    next_cycle();
    bus.d_req = 0; bus.d_we = 0;
    repeat (2) next_cycle();
    chk("lit_wr_len_n", en_len.size(), base + 1);
    if (en_len.size() > base) chk("lit_wr_len", en_len[base], 4);

    // CPU read that never gets m_ready
    plan(255, 32'h7777_7777);
    bus.c_we = 0; bus.c_addr = 32'h200; bus.c_req = 1;
    base = en_len.size();
    wait_ack(1'b0, ok);
    chk("lit_to_c_err", bus.c_err, 1'b1);
    chk("lit_to_c_rdata", bus.c_rdata, 32'hDEADBEEF);
    next_cycle();
    bus.c_req = 0;
    repeat (2) next_cycle();
    chk("lit_to_len_n", en_len.size(), base + 1);
    if (en_len.size() > base) chk("lit_to_len", en_len[base], TO);

    // CPU request held through its ack: a second access follows immediately
    plan(0, 32'h3333_0001); plan(0, 32'h3333_0002);
    bus.c_addr = 32'h300; bus.c_req = 1;
    base = rise_cyc.size();
    ca = c_acks;
    wait_ack(1'b0, ok);
    a1 = cyc;
    wait_ack(1'b0, ok);
    next_cycle();
    bus.c_req = 0;
    repeat (3) next_cycle();
    chk("lit_hold_acks", c_acks - ca, 2);
    if (rise_cyc.size() >= base + 2) chk("lit_hold_start", rise_cyc[base+1] - a1, 2);
    chk("lit_hold_c_rdata", bus.c_rdata, 32'h3333_0002);

    // reset during a CPU write, then a tie goes to the CPU
    plan(255, 32'h0);
    bus.c_we = 1; bus.c_addr = 32'h500; bus.c_wdata = 32'hCAFE_F00D; bus.c_req = 1;
    repeat (3) next_cycle();
    chk("lit_abort_busy", bus.m_en, 1'b1);
    ca = c_acks;
    resetn = 0;
    #1;
    chk("lit_abort_m_en", bus.m_en, 1'b0);
    chk("lit_abort_m_we", bus.m_we, 1'b0);
    chk("lit_abort_m_wdata", bus.m_wdata, 32'h0);
    bus.c_req = 0; bus.c_we = 0;
    repeat (2) next_cycle();
    plan(0, 32'h4444_0001);
    bus.c_addr = 32'h10; bus.d_addr = 32'h20;
    bus.c_req = 1; bus.d_req = 1;
    base = rise_addr.size();
    resetn = 1;
    wait_any(who, ok);
    chk("lit_abort_tie_cpu", who, 1'b0);
    next_cycle();
    bus.c_req = 0; bus.d_req = 0;
    repeat (3) next_cycle();
    chk("lit_abort_acks", c_acks - ca, 1);
    if (rise_addr.size() > base) chk("lit_abort_tie_addr", rise_addr[base], 32'h10);

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
